// File: rtl/huffman_tree_builder_p.sv
// Huffman tree builder: loads a symbol-frequency table, then repeatedly merges the two
// lightest active nodes (ties broken by lower index) until one root remains.
module huffman_tree_builder_p #(
   parameter int  NUM_SYM = 128,
   parameter int  CNT_W   = 16,
   localparam int SYM_W   = $clog2(NUM_SYM),
   localparam int NODE_W  = $clog2(2*NUM_SYM),
   localparam int WGT_W   = CNT_W + SYM_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [CNT_W-1:0]  in_count,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              err_empty,
   output logic [NODE_W-1:0] root,
   output logic [SYM_W:0]    num_leaves,
   input  logic [NODE_W-1:0] rd_addr,
   output logic [NODE_W-1:0] rd_parent,
   output logic              rd_bit,
   output logic [WGT_W-1:0]  rd_weight
);

   localparam int                NNODE     = 1 << NODE_W;
   localparam int                NL_W      = SYM_W + 1;
   localparam logic [SYM_W-1:0]  LAST_SYM  = SYM_W'(NUM_SYM - 1);
   localparam logic [NODE_W-1:0] FIRST_INT = NODE_W'(NUM_SYM);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_MERGE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [SYM_W-1:0]    beat_q, beat_d;
   logic [NL_W-1:0]     nl_q, nl_d;
   logic [NL_W-1:0]     mcnt_q, mcnt_d;
   logic                err_q, err_d;
   logic [NODE_W-1:0]   root_q, root_d;
   logic [NODE_W-1:0]   next_q, next_d;
   logic [NODE_W-1:0]   scan_q, scan_d;
   logic [NNODE-1:0]    act_q, act_d;
   logic                m1_v_q, m1_v_d, m2_v_q, m2_v_d;
   logic [NODE_W-1:0]   m1_idx_q, m1_idx_d, m2_idx_q, m2_idx_d;
   logic [WGT_W-1:0]    m1_w_q, m1_w_d, m2_w_q, m2_w_d;
   logic [SYM_W-1:0]    single_q, single_d;

   logic [WGT_W-1:0]    weight_q [NNODE];
   logic [NODE_W-1:0]   parent_q [NNODE];
   logic                pbit_q   [NNODE];

   logic [NODE_W-1:0]   rd_parent_q;
   logic                rd_bit_q;
   logic [WGT_W-1:0]    rd_weight_q;

   logic                ld_we, mg_we;
   logic [WGT_W-1:0]    cand_w;
   logic [WGT_W-1:0]    sum_w;
   logic                nz;

   assign cand_w = weight_q[scan_q];
   assign sum_w  = m1_w_q + m2_w_q;
   assign nz     = (in_count != '0);

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      nl_d     = nl_q;
      mcnt_d   = mcnt_q;
      err_d    = err_q;
      root_d   = root_q;
      next_d   = next_q;
      scan_d   = scan_q;
      act_d    = act_q;
      m1_v_d   = m1_v_q;
      m2_v_d   = m2_v_q;
      m1_idx_d = m1_idx_q;
      m2_idx_d = m2_idx_q;
      m1_w_d   = m1_w_q;
      m2_w_d   = m2_w_q;
      single_d = single_q;
      ld_we    = 1'b0;
      mg_we    = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_LOAD;
                  beat_d  = '0;
                  nl_d    = '0;
                  err_d   = 1'b0;
                  act_d   = '0;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  ld_we                     = 1'b1;
                  act_d[NODE_W'(beat_q)]    = nz;
                  beat_d                    = beat_q + SYM_W'(1);
                  if (nz) begin
                     nl_d     = nl_q + NL_W'(1);
                     single_d = beat_q;
                  end
                  if (beat_q == LAST_SYM) begin
                     if (nl_d == '0) begin
                        err_d   = 1'b1;
                        root_d  = '0;
                        state_d = S_DONE;
                     end else if (nl_d == NL_W'(1)) begin
                        root_d  = NODE_W'(single_d);
                        state_d = S_DONE;
                     end else begin
                        next_d  = FIRST_INT;
                        scan_d  = '0;
                        mcnt_d  = '0;
                        m1_v_d  = 1'b0;
                        m2_v_d  = 1'b0;
                        state_d = S_SCAN;
                     end
                  end
               end
            end
            S_SCAN: begin
               // Indices arrive in ascending order, so strict '<' keeps the lower index on ties.
               if (act_q[scan_q]) begin
                  if (!m1_v_q || (cand_w < m1_w_q)) begin
                     m2_v_d   = m1_v_q;
                     m2_idx_d = m1_idx_q;
                     m2_w_d   = m1_w_q;
                     m1_v_d   = 1'b1;
                     m1_idx_d = scan_q;
                     m1_w_d   = cand_w;
                  end else if (!m2_v_q || (cand_w < m2_w_q)) begin
                     m2_v_d   = 1'b1;
                     m2_idx_d = scan_q;
                     m2_w_d   = cand_w;
                  end
               end
               scan_d = scan_q + NODE_W'(1);
               if (scan_q == next_q - NODE_W'(1)) state_d = S_MERGE;
            end
            S_MERGE: begin
               mg_we            = 1'b1;
               act_d[m1_idx_q]  = 1'b0;
               act_d[m2_idx_q]  = 1'b0;
               act_d[next_q]    = 1'b1;
               if (mcnt_q + NL_W'(2) == nl_q) begin
                  root_d  = next_q;
                  state_d = S_DONE;
               end else begin
                  next_d  = next_q + NODE_W'(1);
                  mcnt_d  = mcnt_q + NL_W'(1);
                  scan_d  = '0;
                  m1_v_d  = 1'b0;
                  m2_v_d  = 1'b0;
                  state_d = S_SCAN;
               end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         nl_q    <= '0;
         mcnt_q  <= '0;
         err_q   <= 1'b0;
         root_q  <= '0;
         next_q  <= '0;
         scan_q  <= '0;
         act_q   <= '0;
         m1_v_q  <= 1'b0;
         m2_v_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         nl_q    <= nl_d;
         mcnt_q  <= mcnt_d;
         err_q   <= err_d;
         root_q  <= root_d;
         next_q  <= next_d;
         scan_q  <= scan_d;
         act_q   <= act_d;
         m1_v_q  <= m1_v_d;
         m2_v_q  <= m2_v_d;
      end
   end

   always_ff @(posedge clk) begin
      m1_idx_q <= m1_idx_d;
      m2_idx_q <= m2_idx_d;
      m1_w_q   <= m1_w_d;
      m2_w_q   <= m2_w_d;
      single_q <= single_d;
   end

   // Node tables hold data only; they are never scrubbed by reset or clear.
   always_ff @(posedge clk) begin
      if (ld_we) weight_q[NODE_W'(beat_q)] <= WGT_W'(in_count);
      if (mg_we) begin
         weight_q[next_q]   <= sum_w;
         parent_q[m1_idx_q] <= next_q;
         pbit_q[m1_idx_q]   <= 1'b0;
         parent_q[m2_idx_q] <= next_q;
         pbit_q[m2_idx_q]   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_parent_q <= '0;
         rd_bit_q    <= 1'b0;
         rd_weight_q <= '0;
      end else begin
         rd_parent_q <= parent_q[rd_addr];
         rd_bit_q    <= pbit_q[rd_addr];
         rd_weight_q <= weight_q[rd_addr];
      end
   end

   assign in_ready   = (state_q == S_LOAD);
   assign busy       = (state_q == S_LOAD) || (state_q == S_SCAN) || (state_q == S_MERGE);
   assign done       = (state_q == S_DONE);
   assign err_empty  = err_q;
   assign root       = root_q;
   assign num_leaves = nl_q;
   assign rd_parent  = rd_parent_q;
   assign rd_bit     = rd_bit_q;
   assign rd_weight  = rd_weight_q;

endmodule

// File: doc/huffman_tree_builder_p.md
# huffman_tree_builder_p

Parametrised Huffman tree builder: it accepts a streamed symbol-frequency table and merges the two lightest active nodes until a single root remains. The resulting parent/branch-bit table is exposed through a registered read port. It is the next-generation tree-construction stage behind the AHB frequency reader. Compared with the fixed 128-symbol builder, it adds configurable alphabet size, overflow-safe weights, deterministic tie-breaking, empty/single-symbol handling and an abort input.

## Interface
- NUM_SYM, 128: alphabet size, ≥2; leaves are nodes 0..NUM_SYM-1.
- CNT_W, 16: width of each input count.
- Derived: SYM_W = $clog2(NUM_SYM); NODE_W = $clog2(2*NUM_SYM); WGT_W = CNT_W+SYM_W.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a build; sampled only in IDLE.
- clear  in  1  synchronous abort to IDLE; wins over every other input.
- in_valid  in  1  count beat valid.
- in_count  in  CNT_W  count for the next symbol; beats arrive in symbol order 0..NUM_SYM-1.
- in_ready  out  1  high in LOAD.
- busy  out  1  high in LOAD/SCAN/MERGE.
- done  out  1  one-cycle pulse at build end.
- err_empty  out  1  set when all counts are 0; cleared by the next start.
- root  out  NODE_W  root node index; valid from done until the next start.
- num_leaves  out  SYM_W+1  number of nonzero-count symbols.
- rd_addr  in  NODE_W  node index to read.
- rd_parent  out  NODE_W  parent of rd_addr, registered.
- rd_bit  out  1  branch bit: 0 = left/lighter, 1 = right.
- rd_weight  out  WGT_W  node weight, registered.

## Operation
- States: IDLE, LOAD, SCAN, MERGE, DONE.
- IDLE → LOAD on start.
- LOAD:
  - Each in_valid&&in_ready beat writes weight[k] = in_count, zero-extended, at k = beat index.
  - It also sets active[k] = (in_count != 0) and increments num_leaves when the count is nonzero.
  - After beat NUM_SYM-1:
    - num_leaves==0: set err_empty, root=0, go to DONE.
    - num_leaves==1: root = index of the single active leaf, go to DONE.
    - otherwise: next_node = NUM_SYM, go to SCAN.
- SCAN:
  - Visits indices i = 0..next_node-1, one per cycle.
  - Inactive entries are skipped in value but still take their cycle.
  - Keeps min1 ≤ min2 ordered by (weight, index): a lower weight wins, and a lower index wins on equal weight.
- MERGE (one cycle):
  - weight[next_node] = weight[min1]+weight[min2].
  - parent[min1] = next_node with bit 0; parent[min2] = next_node with bit 1.
  - active[min1] = active[min2] = 0; active[next_node] = 1.
  - If this merge was number num_leaves-1: root = next_node, go to DONE.
  - Otherwise: next_node++, return to SCAN with i = 0.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic: weights are WGT_W wide, so the sum of NUM_SYM saturated counts cannot overflow; there is no saturation logic.
- Read port:
  - rd_* reflect the tables at rd_addr one cycle after rd_addr is presented.
  - Contents are defined only for nodes written in the current build, after done.
  - For root, rd_parent is undefined.
  - Reads during busy are permitted and return in-progress values.
- start while busy: ignored.
- clear: forces IDLE, deasserts busy/in_ready, and suppresses done; tables are not scrubbed.
- reset mid-operation: behaves the same as clear, plus all outputs go to their reset values.

## Timing
- Reset values: in_ready 0, busy 0, done 0, err_empty 0, root 0, num_leaves 0, rd_parent 0, rd_bit 0, rd_weight 0. All state is IDLE and all active bits are 0.
- Handshake: start high in IDLE at edge t puts the block in LOAD with in_ready=1 at t+1. A beat transfers on each edge where in_valid&&in_ready. in_valid gaps stall LOAD indefinitely.
- Merge m (m = 0..L-2, L = num_leaves) costs (NUM_SYM+m) SCAN cycles plus 1 MERGE cycle.
- done asserts the cycle after the last MERGE, or the cycle after the last LOAD beat for L ≤ 1.
- Gapless total, start accepted to done: 1 + NUM_SYM + Σ(NUM_SYM+m+1) + 1 cycles.
- busy falls in the same cycle done rises.
- Read latency is exactly 1 cycle.

## Test plan
- NUM_SYM=4, counts {5,1,1,3}:
  - Expected parents: parent[1]=4/0, parent[2]=4/1, parent[4]=5/0, parent[3]=5/1, parent[0]=6/0, parent[5]=6/1.
  - Expected weights: weight[6]=10.
  - Expected outputs: root=6, num_leaves=4.
  - done arrives 1+4+18+1 = 24 cycles after start is accepted.
- NUM_SYM=4, counts {0,0,0,0}: done after LOAD with err_empty=1, root=0, num_leaves=0, and no SCAN cycles.
- NUM_SYM=4, counts {0,0,7,0}: root=2, num_leaves=1, done the cycle after the 4th beat, no merge.
- NUM_SYM=128, CNT_W=16, all counts 16'hFFFF: root weight = 128×65535 = 8388480, exact and not wrapped; root=254.
- Random in_valid gaps plus a start pulse during SCAN: result identical to the gapless run, and the second start is ignored.
- clear asserted mid-SCAN and reset asserted mid-LOAD: IDLE next cycle (reset asynchronously), busy=0, and no done. A subsequent build of {5,1,1,3} reproduces the first scenario.
